// File: rtl/rtc_access_sequencer.sv
// Burst sequencer for the RTC bus-signal generator: runs a full read or write of the
// time/date register set, one generator transaction per register, and muxes the pad bus.
module rtc_access_sequencer #(
    parameter int         NUM_REGS   = 7,
    parameter logic [7:0] ADDR_BASE  = 8'h21,
    parameter logic [7:0] CMD_ADDR   = 8'hF0,
    parameter logic [7:0] CMD_RD_VAL = 8'hF0,
    parameter logic [7:0] CMD_WR_VAL = 8'hF1,
    parameter int         TIMEOUT    = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_read,
    input  logic                  start_write,
    input  logic [8*NUM_REGS-1:0] wr_data,
    input  logic                  gen_flag_done,
    input  logic                  gen_out_direccion_dato,
    input  logic                  gen_rd,
    input  logic [7:0]            bus_in,
    output logic                  gen_en_funcion,
    output logic                  gen_escribir_leer,
    output logic [7:0]            bus_out,
    output logic                  bus_oe,
    output logic [8*NUM_REGS-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_valid,
    output logic                  timeout_err
);
    localparam int TXN_W = $clog2(NUM_REGS + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [TXN_W-1:0] LAST_TXN = TXN_W'(NUM_REGS);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;

    state_t                     r_state, w_next;
    logic                       r_op_rd;
    logic [NUM_REGS-1:0][7:0]   r_snap;
    logic [NUM_REGS-1:0][7:0]   r_rd;
    logic [TXN_W-1:0]           r_txn;
    logic [WD_W-1:0]            r_wd;
    logic                       r_wel;
    logic                       r_rd_prev;
    logic                       r_tout;

    logic                       w_accept;
    logic                       w_txn_wr;
    logic [7:0]                 w_addr;
    logic [7:0]                 w_wval;
    logic [TXN_W-1:0]           w_slot;
    logic                       w_rd_edge;

    assign w_accept  = (r_state == S_IDLE) && (start_read || start_write);
    assign w_slot    = r_txn - 1'b1;
    assign w_rd_edge = (r_state == S_WAIT) && r_op_rd && (r_txn != '0) && !r_rd_prev && gen_rd;

    // Decode the current transaction: direction, address and write value.
    always_comb begin
        w_txn_wr = 1'b1;
        w_addr   = CMD_ADDR;
        w_wval   = CMD_RD_VAL;
        if (r_op_rd) begin
            if (r_txn != '0) begin
                w_txn_wr = 1'b0;
                w_addr   = ADDR_BASE + 8'(w_slot);
                w_wval   = 8'h00;
            end
        end else if (r_txn != LAST_TXN) begin
            w_addr = ADDR_BASE + 8'(r_txn);
            w_wval = r_snap[r_txn];
        end else begin
            w_wval = CMD_WR_VAL;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (gen_flag_done)       w_next = (r_txn == LAST_TXN) ? S_DONE : S_GAP;
                else if (r_wd == WD_MAX) w_next = S_IDLE;
            end
            S_GAP:   w_next = S_ISSUE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op_rd   <= 1'b0;
            r_snap    <= '0;
            r_rd      <= '0;
            r_txn     <= '0;
            r_wd      <= '0;
            r_wel     <= 1'b0;
            r_rd_prev <= 1'b1;
            r_tout    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rd_prev <= gen_rd;
            // Direction is cleared on the way back to IDLE so it reads 0 for the whole idle period.
            if (w_next == S_IDLE)       r_wel <= 1'b0;
            else if (r_state == S_ISSUE) r_wel <= w_txn_wr;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_rd <= start_read;
                        r_snap  <= wr_data;
                        r_txn   <= '0;
                        r_tout  <= 1'b0;
                    end
                end
                S_ISSUE: r_wd <= '0;
                S_WAIT: begin
                    if (gen_flag_done) begin
                        if (r_txn != LAST_TXN) r_txn <= r_txn + 1'b1;
                    end else if (r_wd == WD_MAX) begin
                        r_tout <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                    if (w_rd_edge) r_rd[w_slot] <= bus_in;
                end
                default: ;
            endcase
        end
    end

    assign busy              = (r_state != S_IDLE);
    assign done              = (r_state == S_DONE);
    assign rd_valid          = (r_state == S_DONE) && r_op_rd;
    assign gen_en_funcion    = (r_state == S_ISSUE);
    assign gen_escribir_leer = r_wel;
    assign timeout_err       = r_tout;
    assign rd_data           = r_rd;
    assign bus_oe            = busy & (~gen_out_direccion_dato | r_wel);
    assign bus_out           = !busy ? 8'h00 : (gen_out_direccion_dato ? w_wval : w_addr);

endmodule

// File: tb/tb_rtc_access_sequencer.sv
// Bench for rtc_access_sequencer: a generator model answers each transaction and logs what it
// saw on the bus; every burst is compared with a transaction list derived from the register map.
module tb_rtc_access_sequencer;
    localparam int N = 7;

    logic           clk = 1'b0;
    logic           reset, start_read, start_write;
    logic [8*N-1:0] wr_data;
    logic           gen_flag_done, gen_dir, gen_rd;
    logic [7:0]     bus_in;
    logic           gen_en_funcion, gen_escribir_leer, bus_oe, busy, done, rd_valid, timeout_err;
    logic [7:0]     bus_out;
    logic [8*N-1:0] rd_data;

    rtc_access_sequencer dut (
        .clk(clk), .reset(reset), .start_read(start_read), .start_write(start_write),
        .wr_data(wr_data), .gen_flag_done(gen_flag_done), .gen_out_direccion_dato(gen_dir),
        .gen_rd(gen_rd), .bus_in(bus_in), .gen_en_funcion(gen_en_funcion),
        .gen_escribir_leer(gen_escribir_leer), .bus_out(bus_out), .bus_oe(bus_oe),
        .rd_data(rd_data), .busy(busy), .done(done), .rd_valid(rd_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rw;
        logic       oe_a;
        logic       oe_d;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    int         checks = 0, errors = 0;
    txn_t       txq[$];
    txn_t       exp_q[$];
    logic [7:0] mdl_rd[N];
    int         hold_txn = -1;
    int         gen_cnt  = 0;
    bit         fixed_rd = 0;
    bit         gen_kill = 0;

    // burst results
    int         r_done_n, r_end_n, r_oe_bad;
    bit         r_rdv, r_busy1, r_tout1;

    // Generator model: address phase, data phase, RD strobe on reads, done flag 24 cycles after issue.
    task automatic run_txn();
        txn_t       t;
        logic [7:0] v;
        int         idx;
        idx = gen_cnt;
        gen_cnt++;
        t = '0;
        v = 8'h00;
        gen_dir = 1'b0;
        for (int j = 1; j <= 25; j++) begin
            @(negedge clk);
            case (j)
                2:  begin t.rw = gen_escribir_leer; t.addr = bus_out; t.oe_a = bus_oe; end
                10: gen_dir = 1'b1;
                12: begin t.data = bus_out; t.oe_d = bus_oe; end
                14: if (!t.rw) begin
                        v = fixed_rd ? 8'h10 + (t.addr - 8'h21) : 8'($urandom);
                        bus_in = v;
                        gen_rd = 1'b0;
                    end
                18: if (!t.rw) begin
                        gen_rd = 1'b1;
                        if (!gen_kill && t.addr >= 8'h21 && t.addr < 8'h21 + N)
                            mdl_rd[t.addr - 8'h21] = v;
                    end
                24: if (idx != hold_txn) gen_flag_done = 1'b1;
                25: begin gen_flag_done = 1'b0; gen_dir = 1'b0; txq.push_back(t); end
                default: ;
            endcase
        end
    endtask

    initial begin
        gen_flag_done = 1'b0; gen_dir = 1'b0; gen_rd = 1'b1; bus_in = 8'h00;
        forever begin
            @(negedge clk);
            if (gen_en_funcion === 1'b1) run_txn();
        end
    end

    function automatic logic [8*N-1:0] mdl_packed();
        logic [8*N-1:0] p;
        for (int i = 0; i < N; i++) p[8*i +: 8] = mdl_rd[i];
        return p;
    endfunction

    function automatic void build_exp(input bit rd, input logic [8*N-1:0] wd);
        exp_q.delete();
        if (rd) begin
            exp_q.push_back({1'b1, 1'b1, 1'b1, 8'hF0, 8'hF0});
            for (int k = 1; k <= N; k++) exp_q.push_back({1'b0, 1'b1, 1'b0, 8'(8'h21 + k - 1), 8'h00});
        end else begin
            for (int k = 0; k < N; k++) exp_q.push_back({1'b1, 1'b1, 1'b1, 8'(8'h21 + k), wd[8*k +: 8]});
            exp_q.push_back({1'b1, 1'b1, 1'b1, 8'hF0, 8'hF1});
        end
    endfunction

    // Drives one start (called at a negedge) and watches until busy falls.
    task automatic run_burst(input bit rd, input bit wr, input int pulse_wr_at, input bit scramble);
        int n;
        n = 0;
        r_done_n = 0; r_end_n = 0; r_oe_bad = 0; r_rdv = 0; r_busy1 = 0; r_tout1 = 0;
        txq.delete();
        gen_cnt = 0;
        start_read = rd; start_write = wr;
        while (n < 600) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start_read = 1'b0; start_write = 1'b0;
                r_busy1 = busy; r_tout1 = timeout_err;
                if (scramble) wr_data = 56'({$urandom(), $urandom()});
            end
            if (n == pulse_wr_at)     start_write = 1'b1;
            if (n == pulse_wr_at + 1) start_write = 1'b0;
            if (!rd && busy && !bus_oe) r_oe_bad++;
            if (done && r_done_n == 0) begin r_done_n = n; r_rdv = rd_valid; end
            if (n > 1 && !busy) begin r_end_n = n; break; end
        end
    endtask

    task automatic check_txns(input string name);
        checks++;
        if (txq.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s txn_count: got %0d want %0d", name, txq.size(), exp_q.size());
        end
        for (int i = 0; i < txq.size() && i < exp_q.size(); i++) begin
            checks++;
            if (txq[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s txn%0d {rw,oe_a,oe_d,addr,data}: got %b %b %b %h %h want %b %b %b %h %h",
                         name, i, txq[i].rw, txq[i].oe_a, txq[i].oe_d, txq[i].addr, txq[i].data,
                         exp_q[i].rw, exp_q[i].oe_a, exp_q[i].oe_d, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset();
        int pulses;
        reset = 1'b1; start_read = 1'b0; start_write = 1'b0; wr_data = '0;
        for (int i = 0; i < N; i++) mdl_rd[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, rd_valid, timeout_err, gen_en_funcion, gen_escribir_leer, bus_oe, bus_out, rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b oe=%b bus=%h rd=%h want all 0",
                     busy, done, bus_oe, bus_out, rd_data);
        end
        reset = 1'b0;
        pulses = 0;
        repeat (10) begin @(negedge clk); if (gen_en_funcion) pulses++; end
        checks++;
        if (pulses != 0 || busy !== 1'b0 || bus_out !== 8'h00) begin
            errors++;
            $display("FAIL idle_quiet: got en_pulses=%0d busy=%b bus=%h want 0 0 00", pulses, busy, bus_out);
        end
    endtask

    task automatic check_done(input string name, input bit want_rdv);
        checks++;
        if (r_done_n != 208 || r_rdv !== want_rdv || r_busy1 !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timing: got done_at=%0d rd_valid=%b busy1=%b want 208 %b 1",
                     name, r_done_n, r_rdv, r_busy1, want_rdv);
        end
        checks++;
        if (rd_data !== mdl_packed()) begin
            errors++;
            $display("FAIL %s rd_data: got %h want %h", name, rd_data, mdl_packed());
        end
    endtask

    task automatic test_read_fixed();
        fixed_rd = 1;
        build_exp(1, '0);
        run_burst(1, 0, -1, 0);
        check_txns("read_fixed");
        check_done("read_fixed", 1);
        checks++;
        if (rd_data !== 56'h16151413121110) begin
            errors++;
            $display("FAIL read_fixed_values: got %h want 16151413121110", rd_data);
        end
        fixed_rd = 0;
    endtask

    task automatic test_write(input bit fixed);
        logic [8*N-1:0] wd;
        for (int i = 0; i < N; i++) wd[8*i +: 8] = fixed ? 8'(i + 1) : 8'($urandom);
        @(negedge clk);
        wr_data = wd;
        build_exp(0, wd);
        run_burst(0, 1, -1, 1);
        check_txns(fixed ? "write_fixed" : "write_rand");
        check_done(fixed ? "write_fixed" : "write_rand", 0);
        checks++;
        if (r_oe_bad != 0) begin
            errors++;
            $display("FAIL write_oe: got %0d cycles with bus_oe=0 want 0", r_oe_bad);
        end
    endtask

    task automatic test_read_rand();
        for (int b = 0; b < 2; b++) begin
            build_exp(1, '0);
            run_burst(1, 0, -1, 0);
            check_txns("read_rand");
            check_done("read_rand", 1);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        build_exp(1, '0);
        run_burst(1, 1, 50, 0);
        check_txns("both_start");
        check_done("both_start", 1);
        pulses = 0;
        repeat (30) begin @(negedge clk); if (gen_en_funcion) pulses++; end
        checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL both_start_extra: got en_pulses=%0d busy=%b want 0 0", pulses, busy);
        end
    endtask

    task automatic test_timeout();
        hold_txn = 3;
        build_exp(1, '0);
        run_burst(1, 0, -1, 0);
        hold_txn = -1;
        checks++;
        if (r_done_n != 0 || r_end_n != 144 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout: got done_at=%0d idle_at=%0d timeout_err=%b want 0 144 1",
                     r_done_n, r_end_n, timeout_err);
        end
        checks++;
        if (txq.size() != 4 || rd_data !== mdl_packed()) begin
            errors++;
            $display("FAIL timeout_partial: got txns=%0d rd=%h want 4 %h", txq.size(), rd_data, mdl_packed());
        end
        repeat (5) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b want 1", timeout_err);
        end
        run_burst(1, 0, -1, 0);
        checks++;
        if (r_tout1 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b want 0", r_tout1);
        end
        check_txns("after_timeout");
        check_done("after_timeout", 1);
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  saw_done;
        n = 0;
        saw_done = 0;
        start_read = 1'b1;
        while (n < 110) begin
            @(negedge clk);
            n++;
            if (n == 1) start_read = 1'b0;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy_before: got %b want 1", busy);
        end
        reset = 1'b1;
        gen_kill = 1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) mdl_rd[i] = 8'h00;
        checks++;
        if ({busy, done, rd_valid, gen_en_funcion, gen_escribir_leer, bus_oe, bus_out, rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b oe=%b bus=%h rd=%h want all 0",
                     busy, done, bus_oe, bus_out, rd_data);
        end
        repeat (40) begin @(negedge clk); if (done || busy) saw_done = 1; end
        gen_kill = 0;
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_mid_quiet: got activity after reset want none");
        end
        build_exp(1, '0);
        run_burst(1, 0, -1, 0);
        check_txns("after_reset");
        check_done("after_reset", 1);
    endtask

    initial begin
        test_reset();
        test_read_fixed();
        test_write(1);
        test_write(0);
        test_read_rand();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
